// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - two-master round-robin data-memory bus arbiter with wait-state sequencing
module data_bus_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 1,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  last_owner_q;
  logic                  we_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;
  logic                  cs_q;
  logic                  mem_we_q;
  logic                  oe_q;
  logic                  cpu_gnt_q;
  logic                  dma_gnt_q;
  logic                  cpu_ack_q;
  logic                  dma_ack_q;

  logic                  pick_dma_d;
  logic                  sel_we_d;
  logic [ADDR_WIDTH-1:0] sel_addr_d;
  logic [DATA_WIDTH-1:0] sel_wdata_d;

  // On a tie the master that did not own the bus last time wins (owner 1 = DMA).
  always_comb begin
    pick_dma_d  = dma_req & (~cpu_req | ~last_owner_q);
    sel_we_d    = pick_dma_d ? dma_we    : cpu_we;
    sel_addr_d  = pick_dma_d ? dma_addr  : cpu_addr;
    sel_wdata_d = pick_dma_d ? dma_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cs_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      oe_q         <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cpu_req | dma_req) begin
            owner_q   <= pick_dma_d;
            we_q      <= sel_we_d;
            addr_q    <= sel_addr_d;
            wdata_q   <= sel_wdata_d;
            cnt_q     <= CNT_WIDTH'(WAIT_STATES);
            cs_q      <= 1'b1;
            mem_we_q  <= sel_we_d;
            oe_q      <= ~sel_we_d;
            cpu_gnt_q <= ~pick_dma_d;
            dma_gnt_q <= pick_dma_d;
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
          end else begin
            if (!we_q) begin
              if (owner_q) dma_rdata_q <= mem_rdata;
              else         cpu_rdata_q <= mem_rdata;
            end
            cs_q      <= 1'b0;
            mem_we_q  <= 1'b0;
            oe_q      <= 1'b0;
            cpu_ack_q <= ~owner_q;
            dma_ack_q <= owner_q;
            state_q   <= ST_ACK;
          end
        end
        ST_ACK: begin
          cpu_ack_q    <= 1'b0;
          dma_ack_q    <= 1'b0;
          cpu_gnt_q    <= 1'b0;
          dma_gnt_q    <= 1'b0;
          last_owner_q <= owner_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_gnt   = cpu_gnt_q;
  assign dma_gnt   = dma_gnt_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_cs    = cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = oe_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
